// File: rtl/sdr_chk_pkg.sv
// Shared types for the SDRAM command-pin timing checker: command decode,
// error codes and the per-bank state encoding.
package sdr_chk_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_REF,
    CMD_MRS,
    CMD_BST
  } sdr_cmd_t;

  typedef enum logic [3:0] {
    ERR_NONE     = 4'd0,
    ERR_TRFC     = 4'd1,
    ERR_REF_OPEN = 4'd2,
    ERR_ACT_OPEN = 4'd3,
    ERR_TRP      = 4'd4,
    ERR_RW_IDLE  = 4'd5,
    ERR_TRCD     = 4'd6,
    ERR_TRAS     = 4'd7,
    ERR_TWR      = 4'd8
  } err_code_t;

  typedef enum logic {
    BANK_IDLE,
    BANK_ACTIVE
  } bank_state_t;

  // Deselected chip (cs_n=1) is treated exactly like an explicit NOP.
  function automatic sdr_cmd_t sdr_cmd_decode(input logic cs_n,
                                              input logic ras_n,
                                              input logic cas_n,
                                              input logic we_n);
    sdr_cmd_t cmd;
    cmd = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        3'b110:  cmd = CMD_BST;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sdr_chk_bank.sv
// One tracked SDRAM bank: IDLE/ACTIVE state, elapsed-cycle counters since the
// last ACT, PRE and WR, and the per-bank violation flags for the current command.
module sdr_chk_bank
  import sdr_chk_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sdr_cmd_t         cmd,
  input  logic             hit,
  input  logic [CNT_W-1:0] cfg_trcd,
  input  logic [CNT_W-1:0] cfg_trp,
  input  logic [CNT_W-1:0] cfg_tras,
  input  logic [CNT_W-1:0] cfg_twr,
  output logic             bank_open,
  output logic             v_act_open,
  output logic             v_trp,
  output logic             v_rw_idle,
  output logic             v_trcd,
  output logic             v_tras,
  output logic             v_twr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  bank_state_t      state_q, state_d;
  logic [CNT_W-1:0] c_act_q, c_act_d;
  logic [CNT_W-1:0] c_pre_q, c_pre_d;
  logic [CNT_W-1:0] c_wr_q,  c_wr_d;
  logic             act_hit, rw_hit, pre_hit, wr_hit, is_active;

  // An event restarts the count at 1 so the value seen by a later command is
  // the number of cycles elapsed; idle counters saturate at all-ones.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic             load);
    logic [CNT_W-1:0] n;
    if (load)      n = CNT_ONE;
    else if (&c)   n = c;
    else           n = c + CNT_ONE;
    return n;
  endfunction

  assign is_active = (state_q == BANK_ACTIVE);
  assign act_hit   = hit && (cmd == CMD_ACT);
  assign rw_hit    = hit && ((cmd == CMD_RD) || (cmd == CMD_WR));
  assign pre_hit   = hit && (cmd == CMD_PRE);
  assign wr_hit    = hit && (cmd == CMD_WR);

  always_comb begin
    state_d = state_q;
    if (act_hit)      state_d = BANK_ACTIVE;
    else if (pre_hit) state_d = BANK_IDLE;
    c_act_d = cnt_step(c_act_q, act_hit);
    c_pre_d = cnt_step(c_pre_q, pre_hit);
    c_wr_d  = cnt_step(c_wr_q,  wr_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BANK_IDLE;
      c_act_q <= '1;
      c_pre_q <= '1;
      c_wr_q  <= '1;
    end else begin
      state_q <= state_d;
      c_act_q <= c_act_d;
      c_pre_q <= c_pre_d;
      c_wr_q  <= c_wr_d;
    end
  end

  assign bank_open  = is_active;
  assign v_act_open = act_hit && is_active;
  assign v_trp      = act_hit && (c_pre_q < cfg_trp);
  assign v_rw_idle  = rw_hit && !is_active;
  assign v_trcd     = rw_hit && (c_act_q < cfg_trcd);
  assign v_tras     = pre_hit && is_active && (c_act_q < cfg_tras);
  assign v_twr      = pre_hit && is_active && (c_wr_q < cfg_twr);

endmodule

// File: rtl/sdr_timing_checker.sv
// SDRAM command-pin protocol monitor: decodes the pins, tracks every bank and
// the refresh recovery window, and reports the highest-priority violation.
module sdr_timing_checker
  import sdr_chk_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BA_W      = 2,
  parameter int ADDR_W    = 13,
  parameter int CNT_W     = 4,
  parameter int ERRC_W    = 16
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_resetn,
  input  logic                 chk_en,
  input  logic                 err_clr,
  input  logic                 sdr_cs_n,
  input  logic                 sdr_ras_n,
  input  logic                 sdr_cas_n,
  input  logic                 sdr_we_n,
  input  logic [BA_W-1:0]      sdr_ba,
  input  logic [ADDR_W-1:0]    sdr_addr,
  input  logic [CNT_W-1:0]     cfg_sdr_trcd_d,
  input  logic [CNT_W-1:0]     cfg_sdr_trp_d,
  input  logic [CNT_W-1:0]     cfg_sdr_tras_d,
  input  logic [CNT_W-1:0]     cfg_sdr_twr_d,
  input  logic [CNT_W-1:0]     cfg_sdr_trcar_d,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 err_valid,
  output logic [3:0]           err_code,
  output logic [BA_W-1:0]      err_bank,
  output logic [ERRC_W-1:0]    err_cnt,
  output logic                 first_err_vld,
  output logic [3:0]           first_err_code
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERRC_W-1:0] ERRC_ONE = {{(ERRC_W-1){1'b0}}, 1'b1};

  sdr_cmd_t             cmd;
  logic [NUM_BANKS-1:0] hit;
  logic [NUM_BANKS-1:0] v_act_open, v_trp, v_rw_idle, v_trcd, v_tras, v_twr;
  logic                 unused_addr_bits;

  logic [CNT_W-1:0]     c_ref_q, c_ref_d;
  logic                 err_valid_q, err_valid_d;
  err_code_t            err_code_q, err_code_d;
  logic [BA_W-1:0]      err_bank_q, err_bank_d;
  logic [ERRC_W-1:0]    err_cnt_q, err_cnt_d;
  logic                 first_vld_q, first_vld_d;
  err_code_t            first_code_q, first_code_d;

  err_code_t            code_c;
  logic [BA_W-1:0]      bank_c;
  logic                 trfc_c, ref_open_c;
  logic [ERRC_W-1:0]    cnt_base;
  logic                 first_base;

  assign cmd = sdr_cmd_decode(sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);
  assign unused_addr_bits = ^{sdr_addr[ADDR_W-1:11], sdr_addr[9:0]};

  // PRE with addr[10] set targets every bank; all other commands target sdr_ba.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign hit[g] = (sdr_ba == BA_W'(g)) || ((cmd == CMD_PRE) && sdr_addr[10]);

    sdr_chk_bank #(
      .CNT_W(CNT_W)
    ) u_bank (
      .clk       (sdram_clk),
      .rst_n     (sdram_resetn),
      .cmd       (cmd),
      .hit       (hit[g]),
      .cfg_trcd  (cfg_sdr_trcd_d),
      .cfg_trp   (cfg_sdr_trp_d),
      .cfg_tras  (cfg_sdr_tras_d),
      .cfg_twr   (cfg_sdr_twr_d),
      .bank_open (bank_open[g]),
      .v_act_open(v_act_open[g]),
      .v_trp     (v_trp[g]),
      .v_rw_idle (v_rw_idle[g]),
      .v_trcd    (v_trcd[g]),
      .v_tras    (v_tras[g]),
      .v_twr     (v_twr[g])
    );
  end

  function automatic logic [BA_W-1:0] first_bit(input logic [NUM_BANKS-1:0] v);
    logic [BA_W-1:0] idx;
    idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (v[i]) idx = BA_W'(i);
    end
    return idx;
  endfunction

  // Fixed-priority selection: error class first, then the lowest offending bank.
  always_comb begin
    trfc_c     = (cmd != CMD_NOP) && (c_ref_q < cfg_sdr_trcar_d);
    ref_open_c = ((cmd == CMD_REF) || (cmd == CMD_MRS)) && (|bank_open);
    code_c     = ERR_NONE;
    bank_c     = '0;
    if (trfc_c) begin
      code_c = ERR_TRFC;
      bank_c = sdr_ba;
    end else if (ref_open_c) begin
      code_c = ERR_REF_OPEN;
      bank_c = first_bit(bank_open);
    end else if (|v_act_open) begin
      code_c = ERR_ACT_OPEN;
      bank_c = first_bit(v_act_open);
    end else if (|v_trp) begin
      code_c = ERR_TRP;
      bank_c = first_bit(v_trp);
    end else if (|v_rw_idle) begin
      code_c = ERR_RW_IDLE;
      bank_c = first_bit(v_rw_idle);
    end else if (|v_trcd) begin
      code_c = ERR_TRCD;
      bank_c = first_bit(v_trcd);
    end else if (|v_tras) begin
      code_c = ERR_TRAS;
      bank_c = first_bit(v_tras);
    end else if (|v_twr) begin
      code_c = ERR_TWR;
      bank_c = first_bit(v_twr);
    end
  end

  // A clear in the same cycle as a new error is applied first, so that error
  // becomes the first one counted and captured.
  always_comb begin
    if (cmd == CMD_REF) c_ref_d = CNT_ONE;
    else if (&c_ref_q)  c_ref_d = c_ref_q;
    else                c_ref_d = c_ref_q + CNT_ONE;

    err_valid_d = chk_en && (code_c != ERR_NONE);
    err_code_d  = err_valid_d ? code_c : ERR_NONE;
    err_bank_d  = err_valid_d ? bank_c : '0;

    cnt_base   = err_clr ? '0 : err_cnt_q;
    first_base = err_clr ? 1'b0 : first_vld_q;

    err_cnt_d    = cnt_base;
    first_vld_d  = first_base;
    first_code_d = err_clr ? ERR_NONE : first_code_q;
    if (err_valid_d) begin
      if (!(&cnt_base)) err_cnt_d = cnt_base + ERRC_ONE;
      if (!first_base) begin
        first_vld_d  = 1'b1;
        first_code_d = code_c;
      end
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      c_ref_q      <= '1;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_bank_q   <= '0;
      err_cnt_q    <= '0;
      first_vld_q  <= 1'b0;
      first_code_q <= ERR_NONE;
    end else begin
      c_ref_q      <= c_ref_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_bank_q   <= err_bank_d;
      err_cnt_q    <= err_cnt_d;
      first_vld_q  <= first_vld_d;
      first_code_q <= first_code_d;
    end
  end

  assign err_valid      = err_valid_q;
  assign err_code       = err_code_q;
  assign err_bank       = err_bank_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_vld  = first_vld_q;
  assign first_err_code = first_code_q;

endmodule

// File: tb/tb_sdr_timing_checker.sv
// Directed-vector bench for sdr_timing_checker with hand-computed expectations;
// the error counter is narrowed to 4 bits so saturation is reachable quickly.
module tb_sdr_timing_checker;

  localparam logic [3:0] P_NOP = 4'b1111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0001;

  logic        sdram_clk;
  logic        sdram_resetn;
  logic        chk_en;
  logic        err_clr;
  logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]  sdr_ba;
  logic [12:0] sdr_addr;
  logic [3:0]  cfg_sdr_trcd_d, cfg_sdr_trp_d, cfg_sdr_tras_d, cfg_sdr_twr_d, cfg_sdr_trcar_d;
  logic [3:0]  bank_open;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [1:0]  err_bank;
  logic [3:0]  err_cnt;
  logic        first_err_vld;
  logic [3:0]  first_err_code;

  int vectors;
  int miscompares;

  sdr_timing_checker #(
    .NUM_BANKS(4),
    .BA_W     (2),
    .ADDR_W   (13),
    .CNT_W    (4),
    .ERRC_W   (4)
  ) dut (
    .sdram_clk      (sdram_clk),
    .sdram_resetn   (sdram_resetn),
    .chk_en         (chk_en),
    .err_clr        (err_clr),
    .sdr_cs_n       (sdr_cs_n),
    .sdr_ras_n      (sdr_ras_n),
    .sdr_cas_n      (sdr_cas_n),
    .sdr_we_n       (sdr_we_n),
    .sdr_ba         (sdr_ba),
    .sdr_addr       (sdr_addr),
    .cfg_sdr_trcd_d (cfg_sdr_trcd_d),
    .cfg_sdr_trp_d  (cfg_sdr_trp_d),
    .cfg_sdr_tras_d (cfg_sdr_tras_d),
    .cfg_sdr_twr_d  (cfg_sdr_twr_d),
    .cfg_sdr_trcar_d(cfg_sdr_trcar_d),
    .bank_open      (bank_open),
    .err_valid      (err_valid),
    .err_code       (err_code),
    .err_bank       (err_bank),
    .err_cnt        (err_cnt),
    .first_err_vld  (first_err_vld),
    .first_err_code (first_err_code)
  );

  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drives one command for exactly one rising edge, then returns #1 after it.
  task automatic applyStimulus(input logic [3:0] pins, input logic [1:0] ba,
                               input logic a10, input logic clr);
    @(negedge sdram_clk);
    {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = pins;
    sdr_ba       = ba;
    sdr_addr     = 13'd0;
    sdr_addr[10] = a10;
    err_clr      = clr;
    @(posedge sdram_clk);
    #1;
    {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = P_NOP;
    err_clr = 1'b0;
  endtask

  task automatic resetDut();
    sdram_resetn = 1'b0;
    {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = P_NOP;
    sdr_ba          = 2'd0;
    sdr_addr        = 13'd0;
    chk_en          = 1'b1;
    err_clr         = 1'b0;
    cfg_sdr_trcd_d  = 4'd0;
    cfg_sdr_trp_d   = 4'd0;
    cfg_sdr_tras_d  = 4'd0;
    cfg_sdr_twr_d   = 4'd0;
    cfg_sdr_trcar_d = 4'd0;
    repeat (2) @(negedge sdram_clk);
    sdram_resetn = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset values
    resetDut();
    #1;
    checkOutput("rst_bank_open", 32'(bank_open), 32'd0);
    checkOutput("rst_err_valid", 32'(err_valid), 32'd0);
    checkOutput("rst_err_code", 32'(err_code), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_first_vld", 32'(first_err_vld), 32'd0);

    // T1: tRCD=3, RD two cycles after ACT fails, three cycles after passes
    cfg_sdr_trcd_d = 4'd3;
    applyStimulus(P_ACT, 2'd0, 1'b0, 1'b0);
    checkOutput("t1_act_clean", 32'(err_valid), 32'd0);
    applyStimulus(P_NOP, 2'd0, 1'b0, 1'b0);
    applyStimulus(P_RD, 2'd0, 1'b0, 1'b0);
    checkOutput("t1_trcd_valid", 32'(err_valid), 32'd1);
    checkOutput("t1_trcd_code", 32'(err_code), 32'd6);
    checkOutput("t1_trcd_bank", 32'(err_bank), 32'd0);
    applyStimulus(P_RD, 2'd0, 1'b0, 1'b0);
    checkOutput("t1_retry_clean", 32'(err_valid), 32'd0);

    // T2: tRP=2, ACT one cycle after PRE fails; two cycles after passes
    resetDut();
    cfg_sdr_trp_d = 4'd2;
    applyStimulus(P_PRE, 2'd1, 1'b0, 1'b0);
    checkOutput("t2_pre_clean", 32'(err_valid), 32'd0);
    applyStimulus(P_ACT, 2'd1, 1'b0, 1'b0);
    checkOutput("t2_trp_code", 32'(err_code), 32'd4);
    checkOutput("t2_trp_bank", 32'(err_bank), 32'd1);
    applyStimulus(P_PRE, 2'd1, 1'b0, 1'b0);
    applyStimulus(P_NOP, 2'd0, 1'b0, 1'b0);
    applyStimulus(P_ACT, 2'd1, 1'b0, 1'b0);
    checkOutput("t2_act_clean", 32'(err_valid), 32'd0);
    checkOutput("t2_bank_open", 32'(bank_open), 32'b0010);

    // T3: PRE-all two cycles after ACT b2, tRAS=5 -> lowest offender is bank 2
    resetDut();
    cfg_sdr_tras_d = 4'd5;
    applyStimulus(P_ACT, 2'd2, 1'b0, 1'b0);
    applyStimulus(P_ACT, 2'd3, 1'b0, 1'b0);
    checkOutput("t3_open_before", 32'(bank_open), 32'b1100);
    applyStimulus(P_PRE, 2'd0, 1'b1, 1'b0);
    checkOutput("t3_tras_code", 32'(err_code), 32'd7);
    checkOutput("t3_tras_bank", 32'(err_bank), 32'd2);
    checkOutput("t3_open_after", 32'(bank_open), 32'b0000);

    // T4: REF with a bank open, then ACT inside the refresh recovery window
    resetDut();
    cfg_sdr_trcar_d = 4'd4;
    applyStimulus(P_ACT, 2'd0, 1'b0, 1'b0);
    applyStimulus(P_REF, 2'd0, 1'b0, 1'b0);
    checkOutput("t4_refopen_code", 32'(err_code), 32'd2);
    checkOutput("t4_refopen_bank", 32'(err_bank), 32'd0);
    applyStimulus(P_NOP, 2'd0, 1'b0, 1'b0);
    applyStimulus(P_ACT, 2'd1, 1'b0, 1'b0);
    checkOutput("t4_trfc_valid", 32'(err_valid), 32'd1);
    checkOutput("t4_trfc_code", 32'(err_code), 32'd1);
    checkOutput("t4_err_cnt", 32'(err_cnt), 32'd2);
    checkOutput("t4_first_code", 32'(first_err_code), 32'd2);

    // T5: 20 errors saturate a 4-bit counter; first code held; clear behaviour
    resetDut();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(P_RD, 2'd0, 1'b0, 1'b0);
      if (i == 13) checkOutput("t5_cnt_14", 32'(err_cnt), 32'd14);
    end
    applyStimulus(P_ACT, 2'd0, 1'b0, 1'b0);
    checkOutput("t5_act_clean", 32'(err_valid), 32'd0);
    applyStimulus(P_ACT, 2'd0, 1'b0, 1'b0);
    checkOutput("t5_actopen_code", 32'(err_code), 32'd3);
    checkOutput("t5_cnt_sat", 32'(err_cnt), 32'd15);
    checkOutput("t5_first_vld", 32'(first_err_vld), 32'd1);
    checkOutput("t5_first_code", 32'(first_err_code), 32'd5);
    applyStimulus(P_NOP, 2'd0, 1'b0, 1'b1);
    checkOutput("t5_clr_cnt", 32'(err_cnt), 32'd0);
    checkOutput("t5_clr_vld", 32'(first_err_vld), 32'd0);
    applyStimulus(P_ACT, 2'd0, 1'b0, 1'b1);
    checkOutput("t5_clrerr_cnt", 32'(err_cnt), 32'd1);
    checkOutput("t5_clrerr_vld", 32'(first_err_vld), 32'd1);
    checkOutput("t5_clrerr_code", 32'(first_err_code), 32'd3);

    // T6: checking disabled still tracks banks; async reset mid-traffic
    resetDut();
    chk_en         = 1'b0;
    cfg_sdr_trcd_d = 4'd3;
    applyStimulus(P_ACT, 2'd0, 1'b0, 1'b0);
    applyStimulus(P_NOP, 2'd0, 1'b0, 1'b0);
    applyStimulus(P_RD, 2'd0, 1'b0, 1'b0);
    checkOutput("t6_dis_valid", 32'(err_valid), 32'd0);
    checkOutput("t6_dis_open", 32'(bank_open), 32'b0001);
    checkOutput("t6_dis_cnt", 32'(err_cnt), 32'd0);
    chk_en = 1'b1;
    applyStimulus(P_RD, 2'd3, 1'b0, 1'b0);
    checkOutput("t6_en_code", 32'(err_code), 32'd5);
    checkOutput("t6_en_bank", 32'(err_bank), 32'd3);
    sdram_resetn = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(err_valid), 32'd0);
    checkOutput("t6_rst_code", 32'(err_code), 32'd0);
    checkOutput("t6_rst_bank", 32'(err_bank), 32'd0);
    checkOutput("t6_rst_open", 32'(bank_open), 32'd0);
    checkOutput("t6_rst_cnt", 32'(err_cnt), 32'd0);
    checkOutput("t6_rst_fvld", 32'(first_err_vld), 32'd0);
    checkOutput("t6_rst_fcode", 32'(first_err_code), 32'd0);
    @(negedge sdram_clk);
    sdram_resetn = 1'b1;
    applyStimulus(P_WR, 2'd0, 1'b0, 1'b0);
    checkOutput("t6_post_rwidle", 32'(err_code), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
